// File: rtl/hls_srl_fifo_v2_if.sv
// Stream FIFO handshake bundle: write side, read side and occupancy status.
// The slave modport is the FIFO view and the master modport is the producer/consumer view.
interface hls_srl_fifo_v2_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_almost_full;
  logic [ADDR_WIDTH:0]   if_count;

  modport slave (
    output if_full_n, if_empty_n, if_dout, if_almost_full, if_count,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  modport master (
    input  if_full_n, if_empty_n, if_dout, if_almost_full, if_count,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/hls_srl_fifo_v2.sv
// SRL-based stream FIFO with occupancy count, almost-full flag and an optional
// registered output stage that adds one word of capacity.
module hls_srl_fifo_v2 #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int OUT_REG      = 0,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  hls_srl_fifo_v2_if.slave      s_if
);
  localparam int             CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  AFULL_C = CW'(AFULL_THRESH);
  localparam bit             OREG    = (OUT_REG != 0);

  logic [DATA_WIDTH-1:0] srl_q [DEPTH];
  logic [CW-1:0]         core_cnt_q, core_cnt_d;
  logic [CW-1:0]         count_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  ov_q, ov_d;
  logic                  afull_q, afull_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] tap;
  logic                  empty_n, push, pop, core_pop;

  assign empty_n  = OREG ? ov_q : empty_n_q;
  assign push     = s_if.if_write & s_if.if_write_ce & full_n_q;
  assign pop      = s_if.if_read & s_if.if_read_ce & empty_n;
  // With the output stage, the core refills it whenever it is empty or being drained.
  assign core_pop = OREG ? ((core_cnt_q != '0) & (~ov_q | pop)) : pop;

  always_ff @(posedge clk_i) begin
    if (push) begin
      srl_q[0] <= s_if.if_din;
      for (int i = 1; i < DEPTH; i++) srl_q[i] <= srl_q[i-1];
    end
  end

  always_comb begin
    tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (core_cnt_q == CW'(i + 1)) tap = srl_q[i];
    end
  end

  always_comb begin
    core_cnt_d = core_cnt_q;
    ov_d       = ov_q;
    dout_d     = dout_q;
    if (push & ~core_pop)      core_cnt_d = core_cnt_q + CW'(1);
    else if (core_pop & ~push) core_cnt_d = core_cnt_q - CW'(1);
    if (OREG) begin
      if (core_pop) begin
        ov_d   = 1'b1;
        dout_d = tap;
      end else if (pop) begin
        ov_d   = 1'b0;
      end
    end else begin
      ov_d = 1'b0;
    end
    count_d   = core_cnt_d + CW'(ov_d);
    full_n_d  = (core_cnt_d != DEPTH_C);
    empty_n_d = (core_cnt_d != '0);
    afull_d   = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_cnt_q <= '0;
      full_n_q   <= 1'b1;
      empty_n_q  <= 1'b0;
      ov_q       <= 1'b0;
      afull_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      core_cnt_q <= core_cnt_d;
      full_n_q   <= full_n_d;
      empty_n_q  <= empty_n_d;
      ov_q       <= ov_d;
      afull_q    <= afull_d;
      dout_q     <= dout_d;
    end
  end

  assign s_if.if_full_n      = full_n_q;
  assign s_if.if_empty_n     = empty_n;
  assign s_if.if_dout        = OREG ? dout_q : tap;
  assign s_if.if_almost_full = afull_q;
  assign s_if.if_count       = core_cnt_q + CW'(ov_q);
endmodule

// File: doc/hls_srl_fifo_v2.md
Name: hls_srl_fifo_v2

Overview:
- Parametrised successor to the per-stream SRL shift-register storage. Wraps SRL storage, read-address/occupancy control, full/empty/almost-full flags and an optional registered output stage into one complete FIFO.
- Sits between dataflow PEs, e.g. start-token and data streams feeding PE_i4xi4 instances.
- Uses the same if_* handshake as existing stream FIFOs. Adds an occupancy count and an almost-full flag for upstream throttling.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- ADDR_WIDTH, 4, SRL address width; must satisfy DEPTH <= 2**ADDR_WIDTH.
- DEPTH, 16, SRL entries; minimum 2.
- OUT_REG, 0, 0 = combinational dout from SRL tap; 1 = registered output stage (capacity DEPTH+1).
- AFULL_THRESH, 14, if_almost_full asserts when if_count >= AFULL_THRESH; must be in 1..DEPTH+OUT_REG.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_full_n  out  1  1 = SRL core can accept a word.
- if_write_ce  in  1  write clock enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  1 = if_dout is valid.
- if_read_ce  in  1  read clock enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  head-of-queue data.
- if_almost_full  out  1  registered occupancy threshold flag.
- if_count  out  ADDR_WIDTH+1  total words held, including the output register.

Behaviour:
- Handshake terms:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - Requests while full or empty are ignored; no state change.
- SRL core:
  - On push, the shift chain moves by one and entry 0 takes if_din.
  - Read tap = entry[core_cnt-1], where core_cnt is registered.
  - SRL contents are never reset.
- Core occupancy (internal, core_pop defined per mode):
  - push & ~core_pop: core_cnt+1.
  - core_pop & ~push: core_cnt-1.
  - Both or neither: unchanged.
  - core_cnt never wraps; push is blocked at DEPTH, core_pop at 0.
- if_full_n: registered, equal to (next core_cnt != DEPTH).
  - Push while full is not accepted, even with a simultaneous pop (no pass-through when full).
- OUT_REG=0:
  - core_pop = pop; if_dout = read tap; if_empty_n registered = (next core_cnt != 0); if_count = core_cnt.
  - A push at edge T makes data readable in cycle T+1.
  - Simultaneous push+pop with core_cnt>=1: count is unchanged and the next-oldest word appears at the tap after the edge.
- OUT_REG=1:
  - Output valid bit ov drives if_empty_n; if_dout is a register.
  - core_pop = (core_cnt != 0) & (~ov | pop). On core_pop, if_dout <= read tap and ov <= 1.
  - On pop & core_cnt == 0: ov <= 0 and if_dout holds its value.
  - if_count = core_cnt + ov.
  - A push at edge T into an empty FIFO makes data readable in cycle T+2.
  - Back-to-back pops at full rate sustain 1 word/cycle.
- if_almost_full: registered, equal to (next if_count >= AFULL_THRESH).
- Ordering: strict FIFO order; no word is lost or duplicated under any mix of push, pop or ce gaps.
- Reset (asynchronous, active-high; effective mid-operation as well):
  - if_full_n=1, if_empty_n=0, if_almost_full=0, if_count=0.
  - core_cnt=0, ov=0, if_dout register=0 (OUT_REG=1).
  - OUT_REG=0: if_dout is don't-care while empty.
  - All stored words are discarded.
  - First push after reset deassertion behaves as a push into an empty FIFO.

Test Plan:
- OUT_REG=0, DEPTH=4: push 0xA,0xB,0xC,0xD on consecutive cycles -> if_full_n=0 after 4th edge, if_count=4; a 5th push is ignored; pops return A,B,C,D, then if_empty_n=0 and if_count=0.
- OUT_REG=0, count=2 holding 0x1,0x2: push 0x3 and pop in same cycle -> pop returns 0x1, if_count stays 2, next heads 0x2 then 0x3.
- OUT_REG=1, DEPTH=4: push 0x55 at edge T -> if_empty_n=0 in cycle T+1, 1 with if_dout=0x55 in T+2; fill to if_count=5 while if_full_n=0 at core_cnt=4.
- AFULL_THRESH=3, DEPTH=4: push 3 words -> if_almost_full rises after 3rd push edge; one pop -> falls after that edge.
- Push/pop with if_write_ce/if_read_ce toggling 0,1,0,1 over 100 random words -> output sequence identical to input, no drops or duplicates.
- Reset asserted asynchronously mid-cycle with count=3 -> outputs go to reset values immediately without a clock edge; after release, push 0x7 -> read returns 0x7, not stale data.
